// File: rtl/sad_min_tracker.sv
// -----------------------------------------------------------------------------
// sad_min_tracker
//
// Full-search motion-estimation controller and minimum-SAD selector. It sits
// directly downstream of a 4x4 SAD processing element (PE). One pass walks a
// SEARCH_W x SEARCH_H candidate window in raster order (x fastest). It drives
// the PE enable and announces each candidate to the pixel feeder. It collects
// the PE's SAD stream PE_LAT cycles later and, at the end of the pass,
// publishes the lowest SAD together with its motion-vector coordinates.
//
// Parameters
//   SEARCH_W    candidate positions per row      (1..256)
//   SEARCH_H    candidate rows                   (1..256)
//   PE_LAT      PE input-sample to sum latency   (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pass request, honoured only while idle
//   sad[11:0]    SAD from the PE sum output
//   pe_enable    PE enable; high while issuing and while draining the PE
//   issue_valid  the candidate on issue_x/issue_y goes to the PE this cycle
//   issue_x/y    issued candidate coordinates
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the pass result is published
//   best_sad     minimum SAD of the last completed pass
//   best_x/y     coordinates of that minimum
// -----------------------------------------------------------------------------
module sad_min_tracker #(
  parameter int SEARCH_W = 16,
  parameter int SEARCH_H = 16,
  parameter int PE_LAT   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] sad,
  output logic        pe_enable,
  output logic        issue_valid,
  output logic [7:0]  issue_x,
  output logic [7:0]  issue_y,
  output logic        busy,
  output logic        done,
  output logic [11:0] best_sad,
  output logic [7:0]  best_x,
  output logic [7:0]  best_y
);

  localparam int                 FLUSH_W    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [7:0]         X_LAST     = 8'(SEARCH_W - 1);
  localparam logic [7:0]         Y_LAST     = 8'(SEARCH_H - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [FLUSH_W-1:0] flush_cnt;
  logic               issue_last;
  logic               flush_last;

  logic [PE_LAT-1:0]  vld_p;
  logic               rx_valid;
  logic [7:0]         rx_x;
  logic [7:0]         rx_y;
  logic               rx_first;

  logic [11:0]        run_sad;
  logic [7:0]         run_x;
  logic [7:0]         run_y;
  logic               take;
  logic [11:0]        run_sad_nxt;
  logic [7:0]         run_x_nxt;
  logic [7:0]         run_y_nxt;

  // Increment with wrap back to zero after the last legal index.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v,
                                          input logic [7:0] last);
    return (v == last) ? 8'd0 : v + 8'd1;
  endfunction

  // Minimum selection: the first result of a pass always loads; afterwards
  // only a strictly smaller SAD replaces the running minimum, so on a tie
  // the candidate seen earliest in raster order is kept.
  function automatic logic sad_better(input logic [11:0] cand,
                                      input logic [11:0] cur,
                                      input logic        first);
    return first || (cand < cur);
  endfunction

  assign issue_last = (issue_x == X_LAST) && (issue_y == Y_LAST);
  assign flush_last = (flush_cnt == FLUSH_LAST);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pe_enable   = 1'b0;
    issue_valid = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        pe_enable   = 1'b1;
        issue_valid = 1'b1;
        if (issue_last) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // PE stays enabled so the last candidates drain out of its pipeline.
        pe_enable = 1'b1;
        if (flush_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else begin
      flush_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage: raster position presented to the PE
  // ---------------------------------------------------------------------------
  // The counters wrap to (0,0) after the final candidate, so they already sit
  // at the origin when the next pass starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_x <= 8'd0;
      issue_y <= 8'd0;
    end else if (state == ISSUE) begin
      issue_x <= wrap_inc(issue_x, X_LAST);
      if (issue_x == X_LAST) begin
        issue_y <= wrap_inc(issue_y, Y_LAST);
      end
    end else begin
      issue_x <= 8'd0;
      issue_y <= 8'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid alignment: vld_p[PE_LAT-1] marks the cycle the matching SAD is on sad
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue_valid;
      for (int i = 1; i < PE_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign rx_valid = vld_p[PE_LAT-1];

  // ---------------------------------------------------------------------------
  // Receive stage: coordinates of the SAD currently on the input
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_x <= 8'd0;
      rx_y <= 8'd0;
    end else if (rx_valid) begin
      rx_x <= wrap_inc(rx_x, X_LAST);
      if (rx_x == X_LAST) begin
        rx_y <= wrap_inc(rx_y, Y_LAST);
      end
    end else if (state == IDLE) begin
      rx_x <= 8'd0;
      rx_y <= 8'd0;
    end
  end

  // The receive counter is at the origin exactly for the first result of a
  // pass, which is what forces the unconditional reload.
  assign rx_first    = (rx_x == 8'd0) && (rx_y == 8'd0);
  assign take        = rx_valid && sad_better(sad, run_sad, rx_first);
  assign run_sad_nxt = take ? sad  : run_sad;
  assign run_x_nxt   = take ? rx_x : run_x;
  assign run_y_nxt   = take ? rx_y : run_y;

  // ---------------------------------------------------------------------------
  // Running-minimum stage (datapath, always reloaded by the first result)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    run_sad <= run_sad_nxt;
    run_x   <= run_x_nxt;
    run_y   <= run_y_nxt;
  end

  // ---------------------------------------------------------------------------
  // Result stage: published at the FLUSH->DONE edge so it is visible with done
  // ---------------------------------------------------------------------------
  // The final SAD is sampled in the last FLUSH cycle, so the published value
  // is taken from the next-state minimum rather than the registered one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= 12'h000;
      best_x   <= 8'd0;
      best_y   <= 8'd0;
    end else if ((state == FLUSH) && flush_last) begin
      best_sad <= run_sad_nxt;
      best_x   <= run_x_nxt;
      best_y   <= run_y_nxt;
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// -----------------------------------------------------------------------------
// tb_sad_min_tracker
//
// Bench for sad_min_tracker. Three instances cover a 4x4, a 16x16 and a 1x1
// search window. A behavioural PE (a PE_LAT-deep delay line that only
// advances while enabled) answers each issued candidate with the SAD stored
// in a per-instance map. Expected results come from scanning that map in
// raster order for the first strict minimum.
// -----------------------------------------------------------------------------
module tb_sad_min_tracker;

  localparam int LAT = 5;
  localparam int NI  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start    [NI];
  logic [11:0] sad      [NI];
  logic        pe_en    [NI];
  logic        iv       [NI];
  logic [7:0]  ix       [NI];
  logic [7:0]  iy       [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic [11:0] bs       [NI];
  logic [7:0]  bx       [NI];
  logic [7:0]  by       [NI];

  logic [11:0] map  [NI][256];
  logic [11:0] pipe [NI][LAT];

  int cyc = 0;
  int done_cnt [NI];
  int done_cyc [NI];
  int en_cnt   [NI];
  int iv_cnt   [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sad_min_tracker #(.SEARCH_W(4), .SEARCH_H(4), .PE_LAT(LAT)) u_4x4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sad(sad[0]),
    .pe_enable(pe_en[0]), .issue_valid(iv[0]), .issue_x(ix[0]), .issue_y(iy[0]),
    .busy(busy[0]), .done(done[0]), .best_sad(bs[0]), .best_x(bx[0]), .best_y(by[0])
  );

  sad_min_tracker #(.SEARCH_W(16), .SEARCH_H(16), .PE_LAT(LAT)) u_16x16 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sad(sad[1]),
    .pe_enable(pe_en[1]), .issue_valid(iv[1]), .issue_x(ix[1]), .issue_y(iy[1]),
    .busy(busy[1]), .done(done[1]), .best_sad(bs[1]), .best_x(bx[1]), .best_y(by[1])
  );

  sad_min_tracker #(.SEARCH_W(1), .SEARCH_H(1), .PE_LAT(LAT)) u_1x1 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .sad(sad[2]),
    .pe_enable(pe_en[2]), .issue_valid(iv[2]), .issue_x(ix[2]), .issue_y(iy[2]),
    .busy(busy[2]), .done(done[2]), .best_sad(bs[2]), .best_x(bx[2]), .best_y(by[2])
  );

  function automatic int dim(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  // Behavioural PE: inputs are observed mid-cycle, the delay line advances at
  // the clock edge when enabled; idle slots carry arbitrary garbage.
  initial begin : pe_model
    logic s_en  [NI];
    logic s_iv  [NI];
    int   s_idx [NI];
    for (int i = 0; i < NI; i++) begin
      sad[i] = 12'd0;
      for (int j = 0; j < LAT; j++) pipe[i][j] = 12'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        s_en[i]  = pe_en[i];
        s_iv[i]  = iv[i];
        s_idx[i] = int'(iy[i]) * dim(i) + int'(ix[i]);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (s_en[i]) begin
          for (int j = LAT - 1; j > 0; j--) pipe[i][j] = pipe[i][j-1];
          pipe[i][0] = s_iv[i] ? map[i][s_idx[i] & 255] : 12'($urandom);
        end
        sad[i] = pipe[i][LAT-1];
      end
    end
  end

  initial begin : monitor
    for (int i = 0; i < NI; i++) begin
      done_cnt[i] = 0; done_cyc[i] = -1; en_cnt[i] = 0; iv_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (done[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (pe_en[i]) en_cnt[i]++;
        if (iv[i]) iv_cnt[i]++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t (limit 1ms)", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers and reference model
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input int i, output int t);
    @(posedge clk);
    #1;
    start[i] = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n0, input int limit);
    int k;
    k = 0;
    while (done_cnt[i] == n0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt[i] == n0) begin
      failures++;
      $display("FAIL done_timeout inst=%0d: no done within %0d cycles, required a done pulse", i, limit);
    end
  endtask

  task automatic fill_random(input int i, input int lo, input int hi);
    for (int k = 0; k < 256; k++) map[i][k] = 12'($urandom_range(hi, lo));
  endtask

  task automatic ref_best(input int i, output logic [11:0] s,
                          output logic [7:0] x, output logic [7:0] y);
    int d;
    d = dim(i);
    s = map[i][0];
    x = 8'd0;
    y = 8'd0;
    for (int k = 1; k < d * d; k++) begin
      if (map[i][k] < s) begin
        s = map[i][k];
        x = 8'(k % d);
        y = 8'(k / d);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({pe_en[i], iv[i], ix[i], iy[i], busy[i], done[i], bs[i], bx[i], by[i]} !== 48'h0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d: got %h, required all zero", i,
                 {pe_en[i], iv[i], ix[i], iy[i], busy[i], done[i], bs[i], bx[i], by[i]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || pe_en[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b pe_enable=%b, required 0 0", busy[0], pe_en[0]);
    end
  endtask

  task automatic test_single_min();
    int t, n0;
    for (int k = 0; k < 256; k++) map[0][k] = 12'd100;
    map[0][1*4+2] = 12'd17;
    n0 = done_cnt[0];
    pulse_start(0, t);
    wait_done(0, n0, 60);
    checks++;
    if (done_cyc[0] !== t + 22) begin
      failures++;
      $display("FAIL single_min_done_cycle: done at t+%0d, required t+22", done_cyc[0] - t);
    end
    checks++;
    if ({bs[0], bx[0], by[0]} !== {12'd17, 8'd2, 8'd1}) begin
      failures++;
      $display("FAIL single_min_best: got sad=%0d x=%0d y=%0d, required 17 2 1", bs[0], bx[0], by[0]);
    end
  endtask

  task automatic test_ties();
    int t, n0;
    for (int k = 0; k < 256; k++) map[0][k] = 12'd200;
    map[0][1]  = 12'd40;
    map[0][15] = 12'd40;
    n0 = done_cnt[0];
    pulse_start(0, t);
    wait_done(0, n0, 60);
    checks++;
    if ({bs[0], bx[0], by[0]} !== {12'd40, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL tie_earliest: got sad=%0d x=%0d y=%0d, required 40 1 0", bs[0], bx[0], by[0]);
    end
  endtask

  task automatic test_issue_seq();
    int t, n0, e0, k, first, last, lim;
    logic [11:0] es;
    logic [7:0]  ex, ey;
    fill_random(0, 0, 4095);
    ref_best(0, es, ex, ey);
    n0 = done_cnt[0];
    e0 = en_cnt[0];
    k = 0; first = -1; last = -1; lim = 0;
    pulse_start(0, t);
    while (done_cnt[0] == n0 && lim < 60) begin
      @(negedge clk);
      lim++;
      if (iv[0]) begin
        checks++;
        if ({ix[0], iy[0]} !== {8'(k % 4), 8'(k / 4)}) begin
          failures++;
          $display("FAIL issue_seq[%0d]: got (%0d,%0d), required (%0d,%0d)", k, ix[0], iy[0], k % 4, k / 4);
        end
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
    end
    checks++;
    if (k !== 16 || first !== t + 1 || last !== t + 16) begin
      failures++;
      $display("FAIL issue_window: %0d issues from t+%0d to t+%0d, required 16 from t+1 to t+16",
               k, first - t, last - t);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (en_cnt[0] - e0 !== 21 || pe_en[0] !== 1'b0) begin
      failures++;
      $display("FAIL pe_enable_span: high %0d cycles, now %b, required 21 then 0", en_cnt[0] - e0, pe_en[0]);
    end
    checks++;
    if ({bs[0], bx[0], by[0]} !== {es, ex, ey}) begin
      failures++;
      $display("FAIL random_4x4_best: got sad=%0d x=%0d y=%0d, required %0d %0d %0d",
               bs[0], bx[0], by[0], es, ex, ey);
    end
  endtask

  task automatic test_start_ignored_back_to_back();
    int t, t2, n0;
    logic [11:0] es;
    logic [7:0]  ex, ey;
    fill_random(0, 0, 4095);
    ref_best(0, es, ex, ey);
    n0 = done_cnt[0];
    pulse_start(0, t);
    repeat (4) @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    while (cyc < t + 22) begin
      @(posedge clk);
      #1;
    end
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || done_cnt[0] - n0 !== 1) begin
      failures++;
      $display("FAIL start_ignored: busy=%b dones=%0d after DONE, required busy 0 and 1 done",
               busy[0], done_cnt[0] - n0);
    end
    checks++;
    if ({bs[0], bx[0], by[0]} !== {es, ex, ey}) begin
      failures++;
      $display("FAIL pass_a_best: got sad=%0d x=%0d y=%0d, required %0d %0d %0d",
               bs[0], bx[0], by[0], es, ex, ey);
    end
    for (int k = 0; k < 256; k++) map[0][k] = 12'd4095;
    start[0] = 1'b1;
    t2 = cyc;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({bs[0], bx[0], by[0]} !== {es, ex, ey}) begin
      failures++;
      $display("FAIL best_hold: got sad=%0d x=%0d y=%0d mid-pass, required %0d %0d %0d",
               bs[0], bx[0], by[0], es, ex, ey);
    end
    wait_done(0, n0 + 1, 60);
    checks++;
    if (done_cyc[0] !== t2 + 22 || t2 !== t + 23) begin
      failures++;
      $display("FAIL b2b_done_cycle: second start t+%0d done t2+%0d, required t+23 and t2+22",
               t2 - t, done_cyc[0] - t2);
    end
    checks++;
    if ({bs[0], bx[0], by[0]} !== {12'd4095, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL b2b_all_max: got sad=%0d x=%0d y=%0d, required 4095 0 0", bs[0], bx[0], by[0]);
    end
  endtask

  task automatic test_reset_mid_pass();
    int t, n0;
    fill_random(1, 0, 4095);
    n0 = done_cnt[1];
    pulse_start(1, t);
    while (cyc < t + 8) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (iv[1] !== 1'b1 || busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_pass_active: issue_valid=%b busy=%b, required 1 1", iv[1], busy[1]);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({pe_en[1], iv[1], ix[1], iy[1], busy[1], done[1], bs[1], bx[1], by[1]} !== 48'h0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h, required all zero",
               {pe_en[1], iv[1], ix[1], iy[1], busy[1], done[1], bs[1], bx[1], by[1]});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt[1] !== n0) begin
      failures++;
      $display("FAIL aborted_no_done: %0d done pulses after abort, required 0", done_cnt[1] - n0);
    end
    fill_random(1, 6, 4095);
    map[1][255] = 12'd5;
    pulse_start(1, t);
    wait_done(1, n0, 400);
    checks++;
    if (done_cyc[1] !== t + 262) begin
      failures++;
      $display("FAIL full_pass_done_cycle: done at t+%0d, required t+262", done_cyc[1] - t);
    end
    checks++;
    if ({bs[1], bx[1], by[1]} !== {12'd5, 8'd15, 8'd15}) begin
      failures++;
      $display("FAIL full_pass_best: got sad=%0d x=%0d y=%0d, required 5 15 15", bs[1], bx[1], by[1]);
    end
  endtask

  task automatic test_single_candidate();
    int t, n0, e0, i0;
    logic [11:0] v;
    v = 12'($urandom);
    map[2][0] = v;
    n0 = done_cnt[2];
    e0 = en_cnt[2];
    i0 = iv_cnt[2];
    pulse_start(2, t);
    wait_done(2, n0, 30);
    checks++;
    if (done_cyc[2] !== t + 7) begin
      failures++;
      $display("FAIL 1x1_done_cycle: done at t+%0d, required t+7", done_cyc[2] - t);
    end
    checks++;
    if ({bs[2], bx[2], by[2]} !== {v, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL 1x1_best: got sad=%0d x=%0d y=%0d, required %0d 0 0", bs[2], bx[2], by[2], v);
    end
    checks++;
    if (iv_cnt[2] - i0 !== 1 || en_cnt[2] - e0 !== 6) begin
      failures++;
      $display("FAIL 1x1_span: issue cycles %0d enable cycles %0d, required 1 and 6",
               iv_cnt[2] - i0, en_cnt[2] - e0);
    end
  endtask

  task automatic test_random_passes();
    int t, n0, inst, hi;
    logic [11:0] es;
    logic [7:0]  ex, ey;
    for (int r = 0; r < 6; r++) begin
      inst = (r < 3) ? 1 : 0;
      hi   = (r < 3) ? 40 : 4095;
      fill_random(inst, 0, hi);
      ref_best(inst, es, ex, ey);
      n0 = done_cnt[inst];
      pulse_start(inst, t);
      wait_done(inst, n0, 400);
      checks++;
      if (done_cyc[inst] !== t + dim(inst) * dim(inst) + LAT + 1) begin
        failures++;
        $display("FAIL random_done_cycle[%0d]: done at t+%0d, required t+%0d",
                 r, done_cyc[inst] - t, dim(inst) * dim(inst) + LAT + 1);
      end
      checks++;
      if ({bs[inst], bx[inst], by[inst]} !== {es, ex, ey}) begin
        failures++;
        $display("FAIL random_best[%0d]: got sad=%0d x=%0d y=%0d, required %0d %0d %0d",
                 r, bs[inst], bx[inst], by[inst], es, ex, ey);
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_single_min();
    test_ties();
    test_issue_seq();
    test_start_ignored_back_to_back();
    test_reset_mid_pass();
    test_single_candidate();
    test_random_passes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
